// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
//   state_e    : controller FSM states (IDLE, WB, FILL, DONE)
//   ADDR_W     : byte-address width
//   WORD_W     : cache/memory word width
//   tag_width(): tag width derived from line count and words per line
package dcache_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        DONE
    } state_e;

    // Address = tag | index | word offset | byte bit (always 0).
    function automatic int unsigned tag_width(input int unsigned num_lines,
                                              input int unsigned line_words);
        return ADDR_W - 1 - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the direct-mapped data cache.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-low reset (clears valid/dirty only)
//   i_idx             : line index shared by the read and write ports
//   o_tag/o_valid/o_dirty/o_line : combinational read of the indexed line
//   i_word_we         : per-word write enable, all enabled words take i_wdata
//   i_tag_we, i_tag   : tag write
//   i_valid_we/i_valid, i_dirty_we/i_dirty : valid/dirty bit write
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TAG_W      = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [$clog2(NUM_LINES)-1:0]   i_idx,
    output logic [TAG_W-1:0]               o_tag,
    output logic                           o_valid,
    output logic                           o_dirty,
    output logic [LINE_WORDS*WORD_W-1:0]   o_line,
    input  logic [LINE_WORDS-1:0]          i_word_we,
    input  logic [WORD_W-1:0]              i_wdata,
    input  logic                           i_tag_we,
    input  logic [TAG_W-1:0]               i_tag,
    input  logic                           i_valid_we,
    input  logic                           i_valid,
    input  logic                           i_dirty_we,
    input  logic                           i_dirty
);

    logic [TAG_W-1:0]  r_tag   [NUM_LINES];
    logic [WORD_W-1:0] r_data  [NUM_LINES][LINE_WORDS];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    // Tags and data need no reset: valid=0 masks them.
    always_ff @(posedge i_clk) begin
        if (i_tag_we) begin
            r_tag[i_idx] <= i_tag;
        end
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (i_word_we[w]) begin
                r_data[i_idx][w] <= i_wdata;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_valid_we) begin
                r_valid[i_idx] <= i_valid;
            end
            if (i_dirty_we) begin
                r_dirty[i_idx] <= i_dirty;
            end
        end
    end

    always_comb begin
        o_tag   = r_tag[i_idx];
        o_valid = r_valid[i_idx];
        o_dirty = r_dirty[i_idx];
        o_line  = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            o_line[w*WORD_W +: WORD_W] = r_data[i_idx][w];
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally in one cycle; misses write back a dirty victim
// word by word, refill the line, then complete in a DONE cycle.
// Ports:
//   clk, rst (async active-low), Addr/DataIn/Rd/Wr : pipeline request
//   DataOut/Done/Stall/CacheHit/Err                : pipeline response
//   mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata/mem_ack : word-wide main-memory port
// Optional: define DCACHE_STATS_EN to add saturating req_count/hit_count outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        Err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] req_count,
    output logic [15:0] hit_count
`endif
);

    localparam int unsigned OW    = $clog2(LINE_WORDS);
    localparam int unsigned IW    = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = tag_width(NUM_LINES, LINE_WORDS);
    localparam logic [OW-1:0] CNT_LAST = OW'(LINE_WORDS - 1);

    state_e r_state, w_state_nxt;
    logic [OW-1:0] r_cnt, w_cnt_nxt;

    logic [TAG_W-1:0] w_tag;
    logic [IW-1:0]    w_idx;
    logic [OW-1:0]    w_off;

    logic [TAG_W-1:0]             w_arr_tag;
    logic                         w_arr_valid;
    logic                         w_arr_dirty;
    logic [LINE_WORDS*WORD_W-1:0] w_arr_line;
    logic [WORD_W-1:0]            w_off_word;
    logic [WORD_W-1:0]            w_cnt_word;

    logic [LINE_WORDS-1:0] w_word_we;
    logic [WORD_W-1:0]     w_wdata;
    logic                  w_tag_we, w_valid_we, w_valid, w_dirty_we, w_dirty;

    logic        w_req, w_bad, w_hit;
    logic [15:0] w_dout, w_maddr, w_mwdata;
    logic        w_done, w_stall, w_chit, w_err, w_mrd, w_mwr;

    assign w_tag = Addr[ADDR_W-1 -: TAG_W];
    assign w_idx = Addr[OW+IW -: IW];
    assign w_off = Addr[OW:1];

    assign w_off_word = w_arr_line[32'(w_off) * WORD_W +: WORD_W];
    assign w_cnt_word = w_arr_line[32'(r_cnt) * WORD_W +: WORD_W];

    assign w_req = Rd ^ Wr;
    assign w_bad = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
    assign w_hit = w_arr_valid && (w_arr_tag == w_tag);

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .LINE_WORDS(LINE_WORDS),
        .TAG_W     (TAG_W)
    ) u_array (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_idx     (w_idx),
        .o_tag     (w_arr_tag),
        .o_valid   (w_arr_valid),
        .o_dirty   (w_arr_dirty),
        .o_line    (w_arr_line),
        .i_word_we (w_word_we),
        .i_wdata   (w_wdata),
        .i_tag_we  (w_tag_we),
        .i_tag     (w_tag),
        .i_valid_we(w_valid_we),
        .i_valid   (w_valid),
        .i_dirty_we(w_dirty_we),
        .i_dirty   (w_dirty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_we   = '0;
        w_wdata     = DataIn;
        w_tag_we    = 1'b0;
        w_valid_we  = 1'b0;
        w_valid     = 1'b0;
        w_dirty_we  = 1'b0;
        w_dirty     = 1'b0;
        w_dout      = '0;
        w_maddr     = '0;
        w_mwdata    = '0;
        w_done      = 1'b0;
        w_stall     = 1'b0;
        w_chit      = 1'b0;
        w_err       = 1'b0;
        w_mrd       = 1'b0;
        w_mwr       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_bad) begin
                    w_err  = 1'b1;
                    w_done = 1'b1;
                end else if (w_req) begin
                    if (w_hit) begin
                        w_done = 1'b1;
                        w_chit = 1'b1;
                        if (Rd) begin
                            w_dout = w_off_word;
                        end else begin
                            w_word_we[w_off] = 1'b1;
                            w_dirty_we       = 1'b1;
                            w_dirty          = 1'b1;
                        end
                    end else begin
                        w_stall     = 1'b1;
                        w_state_nxt = (w_arr_valid && w_arr_dirty) ? WB : FILL;
                    end
                end
            end
            WB: begin
                w_stall  = 1'b1;
                w_mwr    = 1'b1;
                w_maddr  = {w_arr_tag, w_idx, r_cnt, 1'b0};
                w_mwdata = w_cnt_word;
                if (mem_ack) begin
                    w_cnt_nxt = r_cnt + OW'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                w_stall = 1'b1;
                w_mrd   = 1'b1;
                w_maddr = {w_tag, w_idx, r_cnt, 1'b0};
                if (mem_ack) begin
                    w_word_we[r_cnt] = 1'b1;
                    w_wdata          = mem_rdata;
                    w_cnt_nxt        = r_cnt + OW'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_tag_we    = 1'b1;
                        w_valid_we  = 1'b1;
                        w_valid     = 1'b1;
                        w_dirty_we  = 1'b1;
                        w_dirty     = 1'b0;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // Completes even if the request was withdrawn during the miss.
                w_done = 1'b1;
                if (Rd) begin
                    w_dout = w_off_word;
                end else if (Wr) begin
                    w_word_we[w_off] = 1'b1;
                    w_dirty_we       = 1'b1;
                    w_dirty          = 1'b1;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Every output is forced low while reset is held.
    always_comb begin
        DataOut   = rst ? w_dout   : '0;
        Done      = rst & w_done;
        Stall     = rst & w_stall;
        CacheHit  = rst & w_chit;
        Err       = rst & w_err;
        mem_rd    = rst & w_mrd;
        mem_wr    = rst & w_mwr;
        mem_addr  = rst ? w_maddr  : '0;
        mem_wdata = rst ? w_mwdata : '0;
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] r_req_count, r_hit_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_count <= '0;
            r_hit_count <= '0;
        end else begin
            if (Done && !Err && (r_req_count != 16'hFFFF)) begin
                r_req_count <= r_req_count + 16'd1;
            end
            if (Done && CacheHit && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
        end
    end

    assign req_count = r_req_count;
    assign hit_count = r_hit_count;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus pushes expected completions and
// memory transfers into queues; a negedge monitor pops and compares them.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
    logic        Rd, Wr, Done, Stall, CacheHit, Err, mem_rd, mem_wr, mem_ack;
`ifdef DCACHE_STATS_EN
    logic [15:0] req_count, hit_count;
`endif

    typedef struct {
        string       name;
        bit          chk_data;
        logic [15:0] data;
        logic        hit;
        logic        err;
    } resp_t;

    typedef struct {
        string       name;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_t;

    resp_t resp_q[$];
    mem_t  mem_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    dcache_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .Addr     (Addr),
        .DataIn   (DataIn),
        .Rd       (Rd),
        .Wr       (Wr),
        .DataOut  (DataOut),
        .Done     (Done),
        .Stall    (Stall),
        .CacheHit (CacheHit),
        .Err      (Err),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .req_count(req_count),
        .hit_count(hit_count)
`endif
    );

    // Memory: acks every cycle it sees a request; read data is 0xA000 + word offset.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = rst && (mem_rd || mem_wr);
            mem_rdata = 16'hA000 + 16'(mem_addr[2:1]);
        end
    end

    // Monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (Done) begin
                n_tests++;
                if (resp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: Done=1 at Addr=%h, none expected", Addr);
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    if (CacheHit !== e.hit || Err !== e.err || (e.chk_data && DataOut !== e.data)) begin
                        n_fail++;
                        $display("FAIL %s: got hit=%b err=%b data=%h, want hit=%b err=%b data=%h",
                                 e.name, CacheHit, Err, DataOut, e.hit, e.err, e.data);
                    end
                end
            end
            if (mem_ack && (mem_rd || mem_wr)) begin
                n_tests++;
                if (mem_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_unexpected: rd=%b wr=%b addr=%h, none expected",
                             mem_rd, mem_wr, mem_addr);
                end else begin
                    mem_t m;
                    m = mem_q.pop_front();
                    if (mem_wr !== m.wr || mem_rd !== !m.wr || mem_addr !== m.addr ||
                        (m.wr && mem_wdata !== m.wdata)) begin
                        n_fail++;
                        $display("FAIL %s: got rd=%b wr=%b addr=%h wdata=%h, want wr=%b addr=%h wdata=%h",
                                 m.name, mem_rd, mem_wr, mem_addr, mem_wdata, m.wr, m.addr, m.wdata);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic exp_resp(input string name, input bit chk, input logic [15:0] data,
                            input logic hit, input logic err);
        resp_t e;
        e.name = name; e.chk_data = chk; e.data = data; e.hit = hit; e.err = err;
        resp_q.push_back(e);
    endtask

    task automatic exp_mem(input string name, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata);
        mem_t m;
        m.name = name; m.wr = wr; m.addr = addr; m.wdata = wdata;
        mem_q.push_back(m);
    endtask

    task automatic exp_fill(input string name, input logic [15:0] base);
        for (int i = 0; i < 4; i++) begin
            exp_mem(name, 1'b0, base + 16'(2 * i), 16'h0000);
        end
    endtask

    // Issue a request (called at posedge+2), wait for Done, return cycles taken.
    task automatic req(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] din, output int lat);
        int k;
        Rd = rd; Wr = wr; Addr = addr; DataIn = din;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!Done && k < 40);
        if (!Done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no Done for addr=%h after %0d cycles", addr, k);
        end
        lat = k;
        @(posedge clk);
        #2;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
        repeat (2) @(posedge clk);
        #2;
        // Outputs held low in reset even with an illegal request present.
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0011;
        #1;
        check("rst_done", Done, 0);
        check("rst_err", Err, 0);
        check("rst_stall", Stall, 0);
        check("rst_memrd", mem_rd, 0);
        Rd = 1'b0; Wr = 1'b0; Addr = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // 1: clean miss refill
        exp_fill("t1_fill", 16'h0010);
        exp_resp("t1_done", 1'b1, 16'hA000, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0010, 16'h0, lat);
        check("t1_lat", lat, 6);

        // 2: load hit
        exp_resp("t2_hit", 1'b1, 16'hA001, 1'b1, 1'b0);
        req(1'b1, 1'b0, 16'h0012, 16'h0, lat);
        check("t2_lat", lat, 1);

        // 3: store hit, then conflicting load with dirty victim
        exp_resp("t3_wr", 1'b0, 16'h0, 1'b1, 1'b0);
        req(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat);
        exp_mem("t3_wb0", 1'b1, 16'h0010, 16'hBEEF);
        exp_mem("t3_wb1", 1'b1, 16'h0012, 16'hA001);
        exp_mem("t3_wb2", 1'b1, 16'h0014, 16'hA002);
        exp_mem("t3_wb3", 1'b1, 16'h0016, 16'hA003);
        exp_fill("t3_fill", 16'h0410);
        exp_resp("t3_rd", 1'b1, 16'hA000, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0410, 16'h0, lat);
        check("t3_lat", lat, 10);

`ifdef DCACHE_STATS_EN
        check("t6_req_count", req_count, 4);
        check("t6_hit_count", hit_count, 2);
`endif

        // 4: illegal requests, then proof nothing changed
        exp_resp("t4_odd", 1'b0, 16'h0, 1'b0, 1'b1);
        req(1'b1, 1'b0, 16'h0011, 16'h0, lat);
        check("t4_odd_lat", lat, 1);
        exp_resp("t4_rdwr", 1'b0, 16'h0, 1'b0, 1'b1);
        req(1'b1, 1'b1, 16'h0010, 16'h5555, lat);
        exp_resp("t4_nochg", 1'b1, 16'hA000, 1'b1, 1'b0);
        req(1'b1, 1'b0, 16'h0410, 16'h0, lat);

        // Store miss: refill, then merge in DONE
        exp_fill("sm_fill", 16'h0020);
        exp_resp("sm_done", 1'b0, 16'h0, 1'b0, 1'b0);
        req(1'b0, 1'b1, 16'h0020, 16'h1234, lat);
        exp_resp("sm_rd0", 1'b1, 16'h1234, 1'b1, 1'b0);
        req(1'b1, 1'b0, 16'h0020, 16'h0, lat);
        exp_resp("sm_rd1", 1'b1, 16'hA001, 1'b1, 1'b0);
        req(1'b1, 1'b0, 16'h0022, 16'h0, lat);

        // 5: reset in the 2nd FILL cycle (victim tag 4 is clean)
        exp_mem("t5_fill0", 1'b0, 16'h0010, 16'h0);
        Rd = 1'b1; Addr = 16'h0010;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("t5_in_fill", mem_rd, 1);
        #1;
        rst = 1'b0;
        #1;
        check("t5_memrd_drop", mem_rd, 0);
        check("t5_stall_drop", Stall, 0);
        check("t5_done_low", Done, 0);
        Rd = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        exp_fill("t5_refill", 16'h0010);
        exp_resp("t5_done", 1'b1, 16'hA000, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0010, 16'h0, lat);
        check("t5_lat", lat, 6);

        repeat (3) @(posedge clk);
        check("resp_q_empty", resp_q.size(), 0);
        check("mem_q_empty", mem_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
